// File: rtl/mem_capture_pkg.sv
// Shared types and helpers for the stream-to-memory capture buffer.
// Holds the state encoding, default widths and the capture-length clamp.
package mem_capture_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 9;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDone    = 2'd2
    } state_e;

    // A zero or oversized length means "fill the whole RAM", so a capture never wraps.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        if (len == 0 || len > depth) begin
            return depth;
        end
        return len;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port with
// old-data read-during-write. Clock enable freezes both ports.
module capture_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_sclr,
    input  logic              i_ce,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_ce && i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Separate process keeps the array reset-free so it maps to block RAM;
    // only the output register is cleared.
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_rdata <= '0;
        end else if (i_ce && i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_capture.sv
// Capture FSM: after arm, writes len valid samples into capture_ram from
// address 0, then flags done; ovf records samples arriving after completion.
module mem_capture
    import mem_capture_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_sclr,
    input  logic              i_ce,
    input  logic              i_arm,
    input  logic [ADDR_W:0]   i_len,
    input  logic [DATA_W-1:0] i_d,
    input  logic              i_d_valid,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_q,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_wr_count,
    output logic              o_ovf
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_wr_count;
    logic [CNT_W-1:0] w_wr_count_d;
    logic [CNT_W-1:0] w_wr_count_inc;
    logic [CNT_W-1:0] r_len_q;
    logic [CNT_W-1:0] w_len_d;
    logic [CNT_W-1:0] w_len_clamped;
    logic             r_ovf;
    logic             w_ovf_d;
    logic             w_we;
    logic             w_ram_we;

    assign w_len_clamped  = CNT_W'(clamp_len(32'(i_len), DEPTH));
    assign w_wr_count_inc = r_wr_count + CNT_W'(1);

    // arm takes priority over d_valid in every state, so a coincident sample is dropped.
    always_comb begin
        w_state_d    = r_state;
        w_wr_count_d = r_wr_count;
        w_len_d      = r_len_q;
        w_ovf_d      = r_ovf;
        w_we         = 1'b0;
        if (i_arm) begin
            w_state_d    = StCapture;
            w_wr_count_d = '0;
            w_len_d      = w_len_clamped;
            w_ovf_d      = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                end
                StCapture: begin
                    if (i_d_valid) begin
                        w_we         = 1'b1;
                        w_wr_count_d = w_wr_count_inc;
                        if (w_wr_count_inc == r_len_q) begin
                            w_state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (i_d_valid) begin
                        w_ovf_d = 1'b1;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_state    <= StIdle;
            r_wr_count <= '0;
            r_len_q    <= '0;
            r_ovf      <= 1'b0;
        end else if (i_ce) begin
            r_state    <= w_state_d;
            r_wr_count <= w_wr_count_d;
            r_len_q    <= w_len_d;
            r_ovf      <= w_ovf_d;
        end
    end

    assign w_ram_we = w_we && !i_sclr;

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_sclr  (i_sclr),
        .i_ce    (i_ce),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_count[ADDR_W-1:0]),
        .i_wdata (i_d),
        .i_re    (i_rd_en),
        .i_raddr (i_rd_addr),
        .o_rdata (o_rd_q)
    );

    assign o_busy     = (r_state == StCapture);
    assign o_done     = (r_state == StDone);
    assign o_wr_count = r_wr_count;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_mem_capture.sv
// Bench for mem_capture: directed scenarios plus random traffic, with a
// behavioural model feeding an expected-output queue drained by a monitor.
module tb_mem_capture;

    localparam int DW    = 16;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          sclr, ce, arm, d_valid, rd_en;
    logic [AW:0]   len;
    logic [DW-1:0] d;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_q;
    logic          busy, done, ovf;
    logic [AW:0]   wr_count;

    always #5 clk = ~clk;

    mem_capture #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .i_clk      (clk),
        .i_sclr     (sclr),
        .i_ce       (ce),
        .i_arm      (arm),
        .i_len      (len),
        .i_d        (d),
        .i_d_valid  (d_valid),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .o_rd_q     (rd_q),
        .o_busy     (busy),
        .o_done     (done),
        .o_wr_count (wr_count),
        .o_ovf      (ovf)
    );

    typedef struct {
        logic          busy;
        logic          done;
        int            cnt;
        logic          ovf;
        logic [DW-1:0] rdq;
        logic          rdq_known;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: "capturing" flag, a sample count towards a target, and a plain array.
    logic          m_capturing = 1'b0;
    logic          m_finished  = 1'b0;
    int            m_cnt       = 0;
    int            m_target    = DEPTH;
    logic          m_ovf       = 1'b0;
    logic [DW-1:0] m_rdq       = '0;
    logic          m_rdq_known = 1'b1;
    logic [DW-1:0] m_mem   [DEPTH];
    logic          m_valid [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic step(input logic s, input logic c, input logic a, input int l,
                        input logic [DW-1:0] dd, input logic dv, input logic re,
                        input int ra);
        exp_t e;
        @(negedge clk);
        sclr = s; ce = c; arm = a; len = (AW+1)'(l); d = dd; d_valid = dv;
        rd_en = re; rd_addr = AW'(ra);
        if (s) begin
            m_capturing = 0; m_finished = 0; m_cnt = 0; m_ovf = 0;
            m_rdq = '0; m_rdq_known = 1;
        end else if (c) begin
            if (re) begin
                m_rdq       = m_mem[ra];
                m_rdq_known = m_valid[ra];
            end
            if (a) begin
                m_capturing = 1; m_finished = 0; m_cnt = 0; m_ovf = 0;
                m_target    = (l == 0 || l > DEPTH) ? DEPTH : l;
            end else if (m_capturing && dv) begin
                m_mem[m_cnt]   = dd;
                m_valid[m_cnt] = 1'b1;
                m_cnt++;
                if (m_cnt == m_target) begin
                    m_capturing = 0;
                    m_finished  = 1;
                end
            end else if (m_finished && dv) begin
                m_ovf = 1;
            end
        end
        e.busy = m_capturing; e.done = m_finished; e.cnt = m_cnt; e.ovf = m_ovf;
        e.rdq = m_rdq; e.rdq_known = m_rdq_known;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        step(0, 1, 0, 0, '0, 0, 1, a);
    endtask

    // Monitor: the DUT presents its outputs every cycle; compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("busy", 32'(busy), 32'(e.busy));
                chk("done", 32'(done), 32'(e.done));
                chk("wr_count", 32'(wr_count), 32'(e.cnt));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                if (e.rdq_known) chk("rd_q", 32'(rd_q), 32'(e.rdq));
            end
        end
    end

    initial begin
        sclr = 1; ce = 1; arm = 0; len = '0; d = '0; d_valid = 0; rd_en = 0; rd_addr = '0;
        step(1, 1, 0, 0, '0, 0, 0, 0);
        step(1, 0, 0, 0, '0, 0, 0, 0);
        idle(1);

        // Basic 4-sample capture and readback.
        step(0, 1, 1, 4, '0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, DW'(16'h1000 + i), 1, 0, 0);
        idle(1);
        for (int i = 0; i < 4; i++) rd(i);
        idle(1);

        // len = 0 and len = 520 both clamp to the full depth.
        step(0, 1, 1, 0, '0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, DW'(i), 1, 0, 0);
        rd(511); rd(0);
        step(0, 1, 1, 520, '0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, DW'(16'h0200 + i), 1, 0, 0);
        rd(511); rd(0);

        // Overflow in DONE leaves RAM unchanged; arm clears it.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'hDEAD, 1, 0, 0);
        rd(0); rd(1); rd(511);
        step(0, 1, 1, 6, '0, 0, 0, 0);

        // Restart after two samples, with a coincident sample that must be dropped.
        step(0, 1, 0, 0, 16'hA000, 1, 0, 0);
        step(0, 1, 0, 0, 16'hA001, 1, 0, 0);
        step(0, 1, 1, 3, 16'hBEEF, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, DW'(16'hC000 + i), 1, 0, 0);
        rd(0); rd(1); rd(2); rd(3);

        // Clock enable low mid-capture freezes everything.
        step(0, 1, 1, 8, '0, 0, 0, 0);
        step(0, 1, 0, 0, 16'hD000, 1, 0, 0);
        step(0, 1, 0, 0, 16'hD001, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, i == 1, 2, 16'hEEEE, 1, 1, 0);
        for (int i = 2; i < 8; i++) step(0, 1, 0, 0, DW'(16'hD000 + i), 1, 0, 0);
        for (int i = 0; i < 8; i++) rd(i);

        // Synchronous clear mid-capture; RAM contents survive.
        step(0, 1, 1, 10, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, DW'(16'hE000 + i), 1, 0, 0);
        step(1, 1, 0, 0, 16'hFFFF, 1, 1, 0);
        idle(1);
        rd(0); rd(2); rd(3);

        // Read-during-write on address 2 returns the old word.
        step(0, 1, 1, 5, '0, 0, 0, 0);
        step(0, 1, 0, 0, 16'h5550, 1, 0, 0);
        step(0, 1, 0, 0, 16'h5551, 1, 0, 0);
        step(0, 1, 0, 0, 16'h5552, 1, 1, 2);
        rd(2);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            int   l;
            logic s, c, a;
            s = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 9) != 0);
            a = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 12) : $urandom_range(0, 520);
            step(s, c, a, l, DW'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1));
        end
        idle(2);

        repeat (2) @(posedge clk);
        #2;
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_capture.md
# mem_capture

Stream-to-memory capture buffer for the ESN signal path, the writer counterpart to the ROM playback path. After an `arm` pulse it writes a programmed number of 16-bit samples from a valid-qualified stream into an internal RAM at incrementing addresses from 0, then stops and flags `done`. Captured data is read back at any time through an independent registered read port. It sits on the divided sample clock downstream of the reservoir output, so recorded states can be dumped or replayed later.

## Interface
- `DATA_W`, 16, sample width
- `ADDR_W`, 9, RAM address width; depth `DEPTH` = 2^ADDR_W = 512
- `clk`  in  1  sample clock (the divided clock); all logic on rising edge
- `sclr`  in  1  synchronous reset, active-high; acts regardless of `ce`
- `ce`  in  1  clock enable; when low, all state, counters, flags and the RAM hold (no write, no read update)
- `arm`  in  1  single-cycle start/restart request
- `len`  in  ADDR_W+1  capture length, sampled only on an accepted `arm`
- `d`  in  DATA_W  sample data
- `d_valid`  in  1  `d` is valid this cycle
- `rd_en`  in  1  read strobe
- `rd_addr`  in  ADDR_W  read address
- `rd_q`  out  DATA_W  read data, registered
- `busy`  out  1  high in CAPTURE
- `done`  out  1  high in DONE
- `wr_count`  out  ADDR_W+1  samples written in the current/last capture
- `ovf`  out  1  sticky: a `d_valid` arrived while in DONE

## Operation
- States: IDLE, CAPTURE, DONE. Reset → IDLE.
- Accepted event = input high with `ce`=1 and `sclr`=0 on the same edge.
- IDLE: `arm` → CAPTURE; `wr_count`←0; latch `len_q` = `len` clamped: `len`=0 or `len`>DEPTH gives DEPTH. `d_valid` ignored.
- CAPTURE: each `d_valid` writes `d` to RAM[`wr_count`[ADDR_W-1:0]] and increments `wr_count`. The write that brings `wr_count` to `len_q` moves the state to DONE on the same edge.
- `arm` in CAPTURE: restart. `wr_count`←0 and `len` is re-latched. If `d_valid` is on the same edge, `arm` wins and that sample is not written.
- DONE: holds `wr_count`=`len_q`. `d_valid` sets `ovf` and is not written. `arm` → CAPTURE, clears `ovf`, restarts as from IDLE.
- Address never wraps. The clamp guarantees at most DEPTH writes per capture.
- Read port: on `rd_en`, `rd_q`←RAM[`rd_addr`]. It is legal in any state. If the same address is written on the same edge, the read returns the old data. `rd_q` holds when `rd_en`=0.
- `sclr` mid-capture: immediate return to IDLE, all outputs to reset values. RAM contents are not cleared.

## Timing
- Reset values: `busy`=0, `done`=0, `wr_count`=0, `ovf`=0, `rd_q`=0, state IDLE.
- All outputs are registered. No combinational path from input to output.
- `busy` rises on the edge that accepts `arm`.
- A sample written on edge N is readable by a read accepted on edge N+1 or later.
- `done`=1 and `busy`=0 after the edge that accepts the final sample. `wr_count`=`len_q` on that same edge.
- Read latency: 1 accepted cycle, from the `rd_en` edge to valid `rd_q`.
- `ce`=0 stretches every latency by the number of disabled cycles. Inputs on disabled cycles are lost, including `arm`, `d_valid` and `rd_en`.
- Back-to-back `d_valid` on every cycle is supported: one write per cycle, no stall.

## Structure
- Shared package `mem_capture_pkg`: state encoding (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2), default `DATA_W`/`ADDR_W`, and the `len` clamp function.
- One sub-module `capture_ram`: simple dual-port, DEPTH×DATA_W, one write port, one registered read port with old-data read-during-write, and clock enable. It must infer block RAM.
- Top level: FSM, `wr_count`, `len_q`, `ovf`.

## Test plan
- Reset, `arm` with `len`=4, `d_valid` continuous with `d`=0x1000..0x1003 → `busy` for 4 cycles, then `done`=1 and `wr_count`=4. Reads of addresses 0–3 return 0x1000–0x1003 one cycle after each `rd_en`.
- `len`=0 and 520 sample 0x0000..0x01FF → both clamp to 512. Final write at address 511, `done` asserted, no wrap over address 0.
- In DONE, apply 3 `d_valid` pulses → `ovf`=1 and RAM unchanged. Then `arm` → `ovf`=0, `busy`=1, `wr_count`=0.
- Re-`arm` after 2 of 6 samples, with `arm` and `d_valid` on the same edge → that sample is dropped. The next sample lands at address 0 and `len` is re-latched.
- Toggle `ce` low for 3 cycles mid-capture while driving `d_valid` → no writes and outputs frozen. Capture resumes with the correct `wr_count`.
- Assert `sclr` mid-capture → IDLE with all outputs 0. Previously written words remain readable. Also read address 2 while writing it → old value returned.
